// File: rtl/c5g_housekeeping_pio_in_edge.sv
// rtl/c5g_housekeeping_pio_in_edge.sv - WIDTH-bit synchronised input port with edge capture, W1C and masked level IRQ
module c5g_housekeeping_pio_in_edge #(
    parameter int          WIDTH          = 8,
    parameter int          SYNC_STAGES    = 2,
    parameter int          EDGE_TYPE      = 0,
    parameter logic [31:0] IRQ_MASK_RESET = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [2:0]       warm_cnt;
    logic             detect_en;
    logic [WIDTH-1:0] edge_sel;
    logic             wr_en;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign sync_q       = sync_r[SYNC_STAGES-1];
    assign detect_en    = (warm_cnt == WARM_DONE);
    assign wr_en        = chipselect & write;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    always_comb begin
        edge_sel = '0;
        case (EDGE_TYPE)
            0:       edge_sel = sync_q & ~prev;
            1:       edge_sel = ~sync_q & prev;
            default: edge_sel = sync_q ^ prev;
        endcase
        if (!detect_en) edge_sel = '0;
    end

    // Warm-up hides the synchroniser filling from reset zeros, so a static-high input is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev     <= '0;
            warm_cnt <= '0;
        end else begin
            prev <= sync_q;
            if (!detect_en) warm_cnt <= warm_cnt + 3'd1;
        end
    end

    // Set term is OR'd after the clear so a same-cycle edge wins over W1C.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edgecapture <= '0;
            irqmask     <= IRQ_MASK_RESET[WIDTH-1:0];
        end else begin
            if (wr_en && address == 2'd3)
                edgecapture <= (edgecapture & ~writedata[WIDTH-1:0]) | edge_sel;
            else
                edgecapture <= edgecapture | edge_sel;
            if (wr_en && address == 2'd2)
                irqmask <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next = 32'(sync_q);
            2'd2:    rd_next = 32'(irqmask);
            2'd3:    rd_next = 32'(edgecapture);
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_next;
            irq      <= |(edgecapture & irqmask);
        end
    end

endmodule

// File: tb/tb_c5g_housekeeping_pio_in_edge.sv
// tb/tb_c5g_housekeeping_pio_in_edge.sv - directed bench for rising, falling and any-edge instances on a shared bus
module tb_c5g_housekeeping_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_r, rd_f, rd_a;
    logic        irq_r, irq_f, irq_a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    c5g_housekeeping_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MASK_RESET(32'h0)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd_r), .irq(irq_r));
    c5g_housekeeping_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_MASK_RESET(32'h0)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd_f), .irq(irq_f));
    c5g_housekeeping_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MASK_RESET(32'h0)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd_a), .irq(irq_a));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write = 1'b0;
        writedata = '0; in_port = 8'hFF;
        idle(3);
        check("reset_rd", rd_r, 32'h0);
        check("reset_irq", {31'b0, irq_r}, 32'h0);
        reset_n = 1'b1;
        idle(8);
        rd(2'd0); check("static_data_r", rd_r, 32'h000000FF); check("static_data_f", rd_f, 32'h000000FF);
        rd(2'd3); check("static_ec_r", rd_r, 32'h0); check("static_ec_f", rd_f, 32'h0); check("static_ec_a", rd_a, 32'h0);
        check("static_irq", {29'b0, irq_r, irq_f, irq_a}, 32'h0);

        in_port = 8'h00; idle(6);
        rd(2'd3); check("fall_ec_r", rd_r, 32'h0); check("fall_ec_f", rd_f, 32'hFF); check("fall_ec_a", rd_a, 32'hFF);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3); check("clr_all_f", rd_f, 32'h0); check("clr_all_a", rd_a, 32'h0);

        // Bit0 rise: capture lands on the third edge, readdata/irq one edge later.
        wr(2'd2, 32'h1);
        address = 2'd3; in_port = 8'h01;
        idle(3);
        check("lat_ec_early", rd_r, 32'h0); check("lat_irq_early", {31'b0, irq_r}, 32'h0);
        idle(1);
        check("lat_ec_r", rd_r, 32'h01); check("lat_irq_r", {31'b0, irq_r}, 32'h1);
        check("rise_ec_f", rd_f, 32'h0); check("rise_irq_f", {31'b0, irq_f}, 32'h0);
        check("rise_ec_a", rd_a, 32'h01); check("rise_irq_a", {31'b0, irq_a}, 32'h1);
        rd(2'd3); check("ec_reread", rd_r, 32'h01);
        wr(2'd3, 32'h1);
        rd(2'd3); check("w1c_ec_r", rd_r, 32'h0); check("w1c_irq_r", {31'b0, irq_r}, 32'h0);

        // Collision: W1C of bit3 lands on the same edge as a new bit3 capture.
        in_port = 8'h09; idle(6);
        rd(2'd3); check("b3_ec_r", rd_r, 32'h08);
        in_port = 8'h01; idle(6);
        in_port = 8'h09; idle(2);
        wr(2'd3, 32'h8);
        idle(2);
        rd(2'd3); check("collide_r", rd_r, 32'h08); check("collide_a", rd_a, 32'h08); check("collide_f", rd_f, 32'h0);
        wr(2'd3, 32'h8);
        rd(2'd3); check("w1c_b3_r", rd_r, 32'h0);

        wr(2'd3, 32'hFF);
        in_port = 8'h29; idle(6);
        wr(2'd3, 32'hFF);
        in_port = 8'h09; idle(6);
        rd(2'd3); check("b5_fall_a", rd_a, 32'h20); check("b5_fall_f", rd_f, 32'h20); check("b5_fall_r", rd_r, 32'h0);
        wr(2'd3, 32'hFF);
        in_port = 8'h29; idle(6);
        rd(2'd3); check("b5_rise_a", rd_a, 32'h20); check("b5_rise_f", rd_f, 32'h0); check("b5_rise_r", rd_r, 32'h20);

        wr(2'd2, 32'h0);
        in_port = 8'h01; idle(6);
        wr(2'd3, 32'hFF);
        in_port = 8'h0D; idle(6);
        rd(2'd3); check("mask0_ec", rd_r, 32'h0C); check("mask0_irq", {31'b0, irq_r}, 32'h0);
        wr(2'd2, 32'h4); idle(1);
        check("mask4_irq", {31'b0, irq_r}, 32'h1);
        rd(2'd2); check("mask4_rd", rd_r, 32'h04);
        wr(2'd2, 32'h0); idle(1);
        check("mask_off_irq", {31'b0, irq_r}, 32'h0);
        rd(2'd3); check("mask_off_ec", rd_r, 32'h0C);

        wr(2'd2, 32'h4);
        address = 2'd3; in_port = 8'h0F; idle(2);
        check("pre_rst_irq", {31'b0, irq_r}, 32'h1);
        reset_n = 1'b0; idle(1); reset_n = 1'b1;
        check("rst_rd", rd_r, 32'h0); check("rst_irq", {31'b0, irq_r}, 32'h0);
        rd(2'd2); check("rst_mask", rd_r, 32'h0);
        rd(2'd1); check("rsvd_rd", rd_r, 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1); check("rsvd_wr", rd_r, 32'h0);
        idle(8);
        rd(2'd3); check("rst_ec_r", rd_r, 32'h0); check("rst_ec_a", rd_a, 32'h0);
        rd(2'd0); check("rst_data", rd_r, 32'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
